prga_decrypt: RTL

PRGA_DECRYPT -- requirements
Module: prga_decrypt

---
 rtl/rc4_pkg.sv | 22 ++
 rtl/prga_decrypt.sv | 130 +++++++++++++
 2 files changed

// File: rtl/rc4_pkg.sv
// Shared types for the RC4 keystream/decrypt datapath.
// Holds the FSM state encoding, the byte type and the default message length.
package rc4_pkg;

    typedef logic [7:0] byte_t;

    localparam int MSG_LEN_DEF = 32;

    typedef enum logic [3:0] {
        IDLE,
        RD_I,
        WT_I,
        RD_J,
        WT_J,
        SWAP_I,
        SWAP_J,
        RD_F,
        WT_F,
        DONE
    } state_t;

endpackage

// File: rtl/prga_decrypt.sv
// RC4 PRGA over a key-scheduled S memory, XORing the keystream with a ROM
// message and writing the plaintext to a RAM, one byte every 8 cycles.
module prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       done,
    output logic [7:0] s_address,
    output logic [7:0] s_data,
    output logic       s_wren,
    input  logic [7:0] s_q,
    output logic [4:0] rom_address,
    input  logic [7:0] rom_q,
    output logic [4:0] d_address,
    output logic [7:0] d_data,
    output logic       d_wren
);

    localparam logic [4:0] K_LAST = 5'(MSG_LEN - 1);

    state_t     state_q, state_d;
    byte_t      i_q, i_d;
    byte_t      j_q, j_d;
    byte_t      si_q, si_d;
    byte_t      sj_q, sj_d;
    logic [4:0] k_q, k_d;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RD_I;
                    i_d     = 8'd1;
                    j_d     = 8'd0;
                    k_d     = 5'd0;
                end
            end
            RD_I:   state_d = WT_I;
            WT_I: begin
                si_d    = s_q;
                j_d     = j_q + s_q;
                state_d = RD_J;
            end
            RD_J:   state_d = WT_J;
            WT_J: begin
                sj_d    = s_q;
                state_d = SWAP_I;
            end
            SWAP_I: state_d = SWAP_J;
            SWAP_J: state_d = RD_F;
            RD_F:   state_d = WT_F;
            WT_F: begin
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 5'd1;
                    i_d     = i_q + 8'd1;
                    state_d = RD_I;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            k_q     <= k_d;
        end
    end

    // Outputs decode from the state register only, so reset clears them at once.
    always_comb begin
        s_address   = '0;
        s_data      = '0;
        s_wren      = 1'b0;
        rom_address = '0;
        d_address   = '0;
        d_data      = '0;
        d_wren      = 1'b0;
        unique case (state_q)
            RD_I: s_address = i_q;
            RD_J: s_address = j_q;
            SWAP_I: begin
                s_address = i_q;
                s_data    = sj_q;
                s_wren    = 1'b1;
            end
            SWAP_J: begin
                s_address = j_q;
                s_data    = si_q;
                s_wren    = 1'b1;
            end
            RD_F: begin
                s_address   = si_q + sj_q;
                rom_address = k_q;
            end
            WT_F: begin
                d_address = k_q;
                d_data    = s_q ^ rom_q;
                d_wren    = 1'b1;
            end
            default: ;
        endcase
    end

    assign done = (state_q == DONE);

endmodule
